// File: rtl/hmc6502_pkg.sv
// Shared definitions for the hmc6502 system: opcodes, FSM state encodings,
// reset vector addresses and the operand-length decoder.
package hmc6502_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] OP_STX_ZP  = 8'h86;
  localparam logic [7:0] OP_STY_ZP  = 8'h84;
  localparam logic [7:0] OP_CMP_IMM = 8'hC9;
  localparam logic [7:0] OP_CPX_IMM = 8'hE0;
  localparam logic [7:0] OP_CPY_IMM = 8'hC0;
  localparam logic [7:0] OP_BEQ     = 8'hF0;
  localparam logic [7:0] OP_BNE     = 8'hD0;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_INY     = 8'hC8;
  localparam logic [7:0] OP_DEX     = 8'hCA;
  localparam logic [7:0] OP_DEY     = 8'h88;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_BRK     = 8'h00;

  localparam logic [2:0] ST_RST_LO = 3'd0;
  localparam logic [2:0] ST_RST_HI = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_OP1    = 3'd3;
  localparam logic [2:0] ST_OP2    = 3'd4;
  localparam logic [2:0] ST_EXEC   = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
  localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;

  typedef enum logic [1:0] {
    AM_IMP,
    AM_ONE,
    AM_ABS
  } amode_t;

  // Number of operand bytes following an opcode. BRK and unknown opcodes are
  // treated as implied so they reach EXEC directly and halt there.
  function automatic amode_t op_mode(input logic [7:0] op);
    amode_t m;
    case (op)
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_LDA_ZP,
      OP_STA_ZP, OP_STX_ZP, OP_STY_ZP,
      OP_CMP_IMM, OP_CPX_IMM, OP_CPY_IMM,
      OP_BEQ, OP_BNE:                      m = AM_ONE;
      OP_JMP_ABS:                          m = AM_ABS;
      default:                             m = AM_IMP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hmc6502_mem.sv
// Program ROM at the top of the address space and data RAM at the bottom.
// Combinational read, write on the rising clock edge.
module hmc6502_mem #(
  parameter int ROM_AW       = 12,
  parameter int RAM_AW       = 11,
  parameter bit ROM_WRITABLE = 1'b0
) (
  input  logic        i_clk,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata
);

  logic [7:0] ROM [0:(1<<ROM_AW)-1];
  logic [7:0] RAM [0:(1<<RAM_AW)-1];

  logic w_rom_sel;
  logic w_ram_sel;

  assign w_rom_sel = &i_addr[15:ROM_AW];
  assign w_ram_sel = ~|i_addr[15:RAM_AW];

  always_comb begin
    o_rdata = 8'h00;
    if (w_rom_sel)
      o_rdata = ROM[i_addr[ROM_AW-1:0]];
    else if (w_ram_sel)
      o_rdata = RAM[i_addr[RAM_AW-1:0]];
  end

  // ROM stays read-only unless a build deliberately enables the shadow write path.
  always_ff @(posedge i_clk) begin
    if (i_we && w_ram_sel)
      RAM[i_addr[RAM_AW-1:0]] <= i_wdata;
    if (ROM_WRITABLE && i_we && w_rom_sel)
      ROM[i_addr[ROM_AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/hmc6502_system.sv
// 6502-subset CPU core with its ROM/RAM; boots through the reset vector and
// runs until BRK or an unsupported opcode halts it.
module hmc6502_system #(
  parameter int ROM_AW = 12,
  parameter int RAM_AW = 11
) (
  input  logic        ph1,
  input  logic        reset,
  output logic        halted,
  output logic [15:0] pc
);
  import hmc6502_pkg::*;

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_a;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [7:0]  r_ir;
  logic [7:0]  r_opl;
  logic [7:0]  r_oph;
  logic        r_z;
  logic        r_n;
  logic        r_c;
  logic        r_halted;

  logic [15:0] w_addr;
  logic        w_we;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rdata;
  logic [7:0]  w_cmp_reg;
  logic [7:0]  w_cmp_diff;
  logic [7:0]  w_x_inc;
  logic [7:0]  w_x_dec;
  logic [7:0]  w_y_inc;
  logic [7:0]  w_y_dec;
  logic [15:0] w_branch_pc;

  assign pc     = r_pc;
  assign halted = r_halted;

  assign w_x_inc     = r_x + 8'd1;
  assign w_x_dec     = r_x - 8'd1;
  assign w_y_inc     = r_y + 8'd1;
  assign w_y_dec     = r_y - 8'd1;
  assign w_branch_pc = r_pc + {{8{r_opl[7]}}, r_opl};
  assign w_cmp_diff  = w_cmp_reg - r_opl;

  always_comb begin
    w_cmp_reg = r_a;
    if (r_ir == OP_CPX_IMM)
      w_cmp_reg = r_x;
    else if (r_ir == OP_CPY_IMM)
      w_cmp_reg = r_y;
  end

  // Address/write mux; a store is suppressed when reset lands on its EXEC cycle.
  always_comb begin
    w_addr  = r_pc;
    w_we    = 1'b0;
    w_wdata = r_a;
    case (r_state)
      ST_RST_LO: w_addr = VEC_RESET_LO;
      ST_RST_HI: w_addr = VEC_RESET_HI;
      ST_EXEC: begin
        case (r_ir)
          OP_LDA_ZP: w_addr = {8'h00, r_opl};
          OP_STA_ZP: begin
            w_addr  = {8'h00, r_opl};
            w_we    = ~reset;
            w_wdata = r_a;
          end
          OP_STX_ZP: begin
            w_addr  = {8'h00, r_opl};
            w_we    = ~reset;
            w_wdata = r_x;
          end
          OP_STY_ZP: begin
            w_addr  = {8'h00, r_opl};
            w_we    = ~reset;
            w_wdata = r_y;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  hmc6502_mem #(
    .ROM_AW      (ROM_AW),
    .RAM_AW      (RAM_AW),
    .ROM_WRITABLE(1'b0)
  ) mem (
    .i_clk  (ph1),
    .i_addr (w_addr),
    .i_we   (w_we),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state  <= ST_RST_LO;
      r_pc     <= 16'h0000;
      r_a      <= 8'h00;
      r_x      <= 8'h00;
      r_y      <= 8'h00;
      r_ir     <= 8'h00;
      r_opl    <= 8'h00;
      r_oph    <= 8'h00;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RST_LO: begin
          r_pc[7:0] <= w_rdata;
          r_state   <= ST_RST_HI;
        end
        ST_RST_HI: begin
          r_pc[15:8] <= w_rdata;
          r_state    <= ST_FETCH;
        end
        ST_FETCH: begin
          r_ir    <= w_rdata;
          r_pc    <= r_pc + 16'd1;
          r_state <= (op_mode(w_rdata) == AM_IMP) ? ST_EXEC : ST_OP1;
        end
        ST_OP1: begin
          r_opl   <= w_rdata;
          r_pc    <= r_pc + 16'd1;
          r_state <= (op_mode(r_ir) == AM_ABS) ? ST_OP2 : ST_EXEC;
        end
        ST_OP2: begin
          r_oph   <= w_rdata;
          r_pc    <= r_pc + 16'd1;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          case (r_ir)
            OP_LDA_IMM: begin
              r_a <= r_opl;
              r_z <= (r_opl == 8'h00);
              r_n <= r_opl[7];
            end
            OP_LDX_IMM: begin
              r_x <= r_opl;
              r_z <= (r_opl == 8'h00);
              r_n <= r_opl[7];
            end
            OP_LDY_IMM: begin
              r_y <= r_opl;
              r_z <= (r_opl == 8'h00);
              r_n <= r_opl[7];
            end
            OP_LDA_ZP: begin
              r_a <= w_rdata;
              r_z <= (w_rdata == 8'h00);
              r_n <= w_rdata[7];
            end
            OP_STA_ZP, OP_STX_ZP, OP_STY_ZP, OP_NOP: ;
            OP_CMP_IMM, OP_CPX_IMM, OP_CPY_IMM: begin
              r_c <= (w_cmp_reg >= r_opl);
              r_z <= (w_cmp_reg == r_opl);
              r_n <= w_cmp_diff[7];
            end
            OP_BEQ: if (r_z) r_pc <= w_branch_pc;
            OP_BNE: if (!r_z) r_pc <= w_branch_pc;
            OP_JMP_ABS: r_pc <= {r_oph, r_opl};
            OP_INX: begin
              r_x <= w_x_inc;
              r_z <= (w_x_inc == 8'h00);
              r_n <= w_x_inc[7];
            end
            OP_INY: begin
              r_y <= w_y_inc;
              r_z <= (w_y_inc == 8'h00);
              r_n <= w_y_inc[7];
            end
            OP_DEX: begin
              r_x <= w_x_dec;
              r_z <= (w_x_dec == 8'h00);
              r_n <= w_x_dec[7];
            end
            OP_DEY: begin
              r_y <= w_y_dec;
              r_z <= (w_y_dec == 8'h00);
              r_n <= w_y_dec[7];
            end
            default: begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
          endcase
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RST_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_hmc6502_system.sv
// Scoreboard bench: each program pushes its expected RAM bytes, runs to halt,
// then drains the queue against the data RAM.
module tb_hmc6502_system;
  import hmc6502_pkg::*;

  logic        ph1;
  logic        reset;
  logic        halted;
  logic [15:0] pc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         addr;
    logic [7:0] data;
    string      name;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] prog[$];

  hmc6502_system #(.ROM_AW(12), .RAM_AW(11)) dut (
    .ph1   (ph1),
    .reset (reset),
    .halted(halted),
    .pc    (pc)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic load_prog();
    for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) dut.mem.ROM[i] = prog[i];
    dut.mem.ROM[4092] = 8'h00;
    dut.mem.ROM[4093] = 8'hF0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (5) @(negedge ph1);
    reset = 1'b0;
  endtask

  task automatic run_to_halt();
    int cyc;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(negedge ph1);
      cyc++;
    end
  endtask

  task automatic test_reset();
    prog = {8'h00};
    load_prog();
    do_reset();
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL reset_halted: got %b want 0", halted);
    end
    checks++;
    if (dut.r_state !== ST_RST_LO) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, ST_RST_LO);
    end
    checks++;
    if ({dut.r_a, dut.r_x, dut.r_y} !== 24'h0 || {dut.r_z, dut.r_n, dut.r_c} !== 3'b000) begin
      errors++; $display("FAIL reset_regs: got a=%h x=%h y=%h znc=%b%b%b want zeros",
                         dut.r_a, dut.r_x, dut.r_y, dut.r_z, dut.r_n, dut.r_c);
    end
    repeat (2) @(negedge ph1);
    checks++;
    if (pc !== 16'hF000) begin
      errors++; $display("FAIL reset_vector_pc: got %h want f000", pc);
    end
    $display("txn reset: pc=%h halted=%b", pc, halted);
  endtask

  task automatic finish_prog(input string tag, input logic [15:0] exp_pc);
    exp_t e;
    run_to_halt();
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL %s_halt: got halted=%b want 1 (timeout)", tag, halted);
    end
    repeat (4) @(negedge ph1);
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL %s_halt_pc: got %h want %h", tag, pc, exp_pc);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.mem.RAM[e.addr] !== e.data) begin
        errors++;
        $display("FAIL %s: RAM[%0d] got %h want %h", e.name, e.addr, dut.mem.RAM[e.addr], e.data);
      end
    end
    $display("txn %s: pc=%h halted=%b", tag, pc, halted);
  endtask

  task automatic test_cmp_branch();
    prog = {8'hA9, 8'h7F, 8'hC9, 8'h7F, 8'hD0, 8'h02, 8'hF0, 8'h05,
            8'hA9, 8'hEE, 8'h85, 8'h15, 8'h00,
            8'h85, 8'h15, 8'h00};
    load_prog();
    sb.push_back('{21, 8'h7F, "cmp_branch_ram21"});
    do_reset();
    finish_prog("cmp_branch", 16'hF010);
  endtask

  task automatic test_not_equal();
    prog = {8'hA9, 8'h10, 8'hC9, 8'h20, 8'hF0, 8'h02, 8'h85, 8'h15,
            8'h85, 8'h00, 8'h85, 8'h02, 8'h00};
    load_prog();
    sb.push_back('{21, 8'h10, "ne_ram21"});
    sb.push_back('{0,  8'h10, "ne_ram0"});
    sb.push_back('{2,  8'h10, "ne_ram2"});
    do_reset();
    finish_prog("not_equal", 16'hF00D);
    checks++;
    if (dut.r_c !== 1'b0 || dut.r_n !== 1'b1 || dut.r_z !== 1'b0) begin
      errors++; $display("FAIL ne_flags: got c=%b n=%b z=%b want c=0 n=1 z=0", dut.r_c, dut.r_n, dut.r_z);
    end
  endtask

  task automatic test_wrap();
    prog = {8'hA2, 8'hFF, 8'hE8, 8'h86, 8'h00, 8'hA0, 8'h00, 8'h88,
            8'h84, 8'h01, 8'h00};
    load_prog();
    sb.push_back('{0, 8'h00, "wrap_inx_ram0"});
    sb.push_back('{1, 8'hFF, "wrap_dey_ram1"});
    do_reset();
    finish_prog("wrap", 16'hF00B);
    checks++;
    if (dut.r_x !== 8'h00 || dut.r_y !== 8'hFF || dut.r_n !== 1'b1 || dut.r_z !== 1'b0) begin
      errors++; $display("FAIL wrap_regs: got x=%h y=%h n=%b z=%b want x=00 y=ff n=1 z=0",
                         dut.r_x, dut.r_y, dut.r_n, dut.r_z);
    end
  endtask

  task automatic test_loop();
    prog = {8'hA2, 8'h05, 8'hCA, 8'hD0, 8'hFD, 8'h86, 8'h02, 8'h00};
    load_prog();
    sb.push_back('{2, 8'h00, "loop_ram2"});
    do_reset();
    finish_prog("loop", 16'hF008);
    checks++;
    if (dut.r_x !== 8'h00 || dut.r_z !== 1'b1) begin
      errors++; $display("FAIL loop_regs: got x=%h z=%b want x=00 z=1", dut.r_x, dut.r_z);
    end
  endtask

  task automatic test_jmp_zp_cpx();
    prog = {8'h4C, 8'h05, 8'hF0, 8'h00, 8'h00,
            8'hA9, 8'h5A, 8'h85, 8'h05, 8'hA9, 8'h00, 8'hA5, 8'h05,
            8'h85, 8'h06, 8'hA2, 8'h09, 8'hE0, 8'h0A, 8'h02};
    load_prog();
    sb.push_back('{5, 8'h5A, "jmp_sta_ram5"});
    sb.push_back('{6, 8'h5A, "lda_zp_ram6"});
    do_reset();
    finish_prog("jmp_zp_cpx", 16'hF014);
    checks++;
    if (dut.r_c !== 1'b0 || dut.r_n !== 1'b1 || dut.r_z !== 1'b0 || dut.r_a !== 8'h5A) begin
      errors++; $display("FAIL cpx_flags: got c=%b n=%b z=%b a=%h want c=0 n=1 z=0 a=5a",
                         dut.r_c, dut.r_n, dut.r_z, dut.r_a);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    prog = {8'hA9, 8'hAA, 8'h85, 8'h15, 8'h00};
    load_prog();
    do_reset();
    cyc = 0;
    while (!(dut.r_state == ST_EXEC && dut.r_ir == OP_STA_ZP) && cyc < 100) begin
      @(negedge ph1);
      cyc++;
    end
    checks++;
    if (!(dut.r_state == ST_EXEC && dut.r_ir == OP_STA_ZP)) begin
      errors++; $display("FAIL mid_reach_exec: got state=%0d ir=%h want EXEC of 85", dut.r_state, dut.r_ir);
    end
    reset = 1'b1;
    @(negedge ph1);
    checks++;
    if (dut.mem.RAM[21] !== 8'h10) begin
      errors++; $display("FAIL mid_no_write: RAM[21] got %h want 10", dut.mem.RAM[21]);
    end
    checks++;
    if (halted !== 1'b0 || dut.r_state !== ST_RST_LO) begin
      errors++; $display("FAIL mid_state: got halted=%b state=%0d want 0 and %0d", halted, dut.r_state, ST_RST_LO);
    end
    repeat (2) @(negedge ph1);
    reset = 1'b0;
    repeat (2) @(negedge ph1);
    checks++;
    if (pc !== 16'hF000) begin
      errors++; $display("FAIL mid_restart_pc: got %h want f000", pc);
    end
    sb.push_back('{21, 8'hAA, "mid_rerun_ram21"});
    finish_prog("reset_mid", 16'hF005);
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_cmp_branch();
    test_not_equal();
    test_wrap();
    test_loop();
    test_jmp_zp_cpx();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
